// File: rtl/down_counter_bla.sv
// rtl/down_counter_bla.sv - 16-bit loadable down counter with IDLE/RUN/DONE control
//
// Purpose:
//   Counts a loaded value down to zero, one step per enabled cycle, and
//   flags the zero cycle with a one-cycle done. The decrement is built from
//   four 4-bit borrow-lookahead slices; no subtract operator is used.
//
// Configuration macro:
//   DOWN_COUNTER_AUTO_RELOAD_EN  when defined, DONE reloads the captured
//                                start value and counting repeats until
//                                abort or rst. When undefined, DONE returns
//                                to IDLE.
//
// Ports:
//   clk         in   1   sole clock, rising edge
//   rst         in   1   synchronous active-high reset
//   load_valid  in   1   load request, taken when load_ready is high
//   load_val    in  16   start value captured on an accepted load
//   load_ready  out  1   high only in IDLE
//   enable      in   1   decrement qualifier in RUN
//   abort       in   1   cancels RUN/DONE, returns to IDLE holding count
//   count       out 16   registered current count
//   busy        out  1   high in RUN and DONE
//   done        out  1   high exactly while in DONE
//   zero        out  1   combinational count == 0

module down_counter_bla (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_valid,
   input  logic [15:0] load_val,
   output logic        load_ready,
   input  logic        enable,
   input  logic        abort,
   output logic [15:0] count,
   output logic        busy,
   output logic        done,
   output logic        zero
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q;
   logic [15:0] count_q;
   logic [15:0] count_d;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
   // The start value is only needed again when DONE reloads it.
   logic [15:0] reload_q;
`endif

   // One 4-bit slice: a bit flips when the slice borrow-in is set and every
   // lower bit of the slice is zero.
   function automatic logic [3:0] dec_slice(input logic [3:0] c, input logic bin);
      logic [3:0] r;
      r[0] = c[0] ^ bin;
      r[1] = c[1] ^ (bin & ~c[0]);
      r[2] = c[2] ^ (bin & ~c[1] & ~c[0]);
      r[3] = c[3] ^ (bin & ~c[2] & ~c[1] & ~c[0]);
      return r;
   endfunction

   logic slice0_zero;
   logic slice1_zero;
   logic slice2_zero;
   logic borrow1;
   logic borrow2;
   logic borrow3;

   assign slice0_zero = ~|count_q[3:0];
   assign slice1_zero = ~|count_q[7:4];
   assign slice2_zero = ~|count_q[11:8];

   // Lookahead: a slice borrows when every lower slice is all zeros.
   assign borrow1 = slice0_zero;
   assign borrow2 = slice0_zero & slice1_zero;
   assign borrow3 = slice0_zero & slice1_zero & slice2_zero;

   assign count_d = {dec_slice(count_q[15:12], borrow3),
                     dec_slice(count_q[11:8],  borrow2),
                     dec_slice(count_q[7:4],   borrow1),
                     dec_slice(count_q[3:0],   1'b1)};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         count_q  <= 16'h0000;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
         reload_q <= 16'h0000;
`endif
      end else begin
         unique case (state_q)
            IDLE: begin
               // abort is meaningless here; a concurrent load still wins.
               if (load_valid) begin
                  count_q  <= load_val;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
                  reload_q <= load_val;
`endif
                  state_q  <= (load_val != 16'h0000) ? RUN : DONE;
               end
            end
            RUN: begin
               if (abort) begin
                  state_q <= IDLE;
               end else if (enable && (count_q != 16'h0000)) begin
                  count_q <= count_d;
                  if (count_q == 16'h0001) begin
                     state_q <= DONE;
                  end
               end
            end
            DONE: begin
               if (abort) begin
                  state_q <= IDLE;
               end else begin
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
                  // A zero reload parks in DONE with done held high.
                  if (reload_q != 16'h0000) begin
                     state_q <= RUN;
                     count_q <= reload_q;
                  end
`else
                  state_q <= IDLE;
`endif
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign count      = count_q;
   assign done       = (state_q == DONE);
   assign busy       = (state_q != IDLE);
   assign load_ready = (state_q == IDLE);
   assign zero       = (count_q == 16'h0000);

endmodule

// File: tb/tb_down_counter_bla.sv
// tb/tb_down_counter_bla.sv - directed scoreboard bench for down_counter_bla

module tb_down_counter_bla;

   logic        clk;
   logic        rst;
   logic        load_valid;
   logic [15:0] load_val;
   logic        load_ready;
   logic        enable;
   logic        abort;
   logic [15:0] count;
   logic        busy;
   logic        done;
   logic        zero;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string       tag;
      logic [15:0] cnt;
      logic        dn;
      logic        bsy;
      logic        lr;
   } exp_t;

   exp_t exp_q[$];

   down_counter_bla dut (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_val   (load_val),
      .load_ready (load_ready),
      .enable     (enable),
      .abort      (abort),
      .count      (count),
      .busy       (busy),
      .done       (done),
      .zero       (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive inputs for one edge, push what the outputs must be after that
   // edge, then pop and compare once the edge has passed.
   task automatic step(input string tag, input logic r, input logic lv,
                       input logic [15:0] val, input logic en, input logic ab,
                       input logic [15:0] e_cnt, input logic e_dn,
                       input logic e_bsy, input logic e_lr);
      exp_t e;
      exp_t o;
      rst        = r;
      load_valid = lv;
      load_val   = val;
      enable     = en;
      abort      = ab;
      e.tag = tag; e.cnt = e_cnt; e.dn = e_dn; e.bsy = e_bsy; e.lr = e_lr;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      o = exp_q.pop_front();
      total++;
      assert (count === o.cnt) else begin
         bad++; $error("FAIL %s count got=%h want=%h", o.tag, count, o.cnt);
      end
      total++;
      assert (done === o.dn) else begin
         bad++; $error("FAIL %s done got=%b want=%b", o.tag, done, o.dn);
      end
      total++;
      assert (busy === o.bsy) else begin
         bad++; $error("FAIL %s busy got=%b want=%b", o.tag, busy, o.bsy);
      end
      total++;
      assert (load_ready === o.lr) else begin
         bad++; $error("FAIL %s load_ready got=%b want=%b", o.tag, load_ready, o.lr);
      end
      total++;
      assert (zero === (o.cnt == 16'h0000)) else begin
         bad++; $error("FAIL %s zero got=%b want=%b", o.tag, zero, (o.cnt == 16'h0000));
      end
   endtask

   initial begin
      rst = 1'b0; load_valid = 1'b0; load_val = 16'h0000; enable = 1'b0; abort = 1'b0;

      // reset state
      step("reset",      1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 1);
      step("idle_hold",  0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 1);

      // load 3, count 3,2,1,0 with one done cycle
      step("ld3",        0, 1, 16'h0003, 1, 0, 16'h0003, 0, 1, 0);
      step("ld3_2",      0, 0, 16'h0000, 1, 0, 16'h0002, 0, 1, 0);
      step("ld3_1",      0, 0, 16'h0000, 1, 0, 16'h0001, 0, 1, 0);
      step("ld3_0",      0, 0, 16'h0000, 1, 0, 16'h0000, 1, 1, 0);
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
      step("ld3_reload", 0, 0, 16'h0000, 1, 0, 16'h0003, 0, 1, 0);
      step("ld3_abort",  0, 0, 16'h0000, 1, 1, 16'h0003, 0, 0, 1);
`else
      step("ld3_idle",   0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 1);
`endif

      // cross-slice borrows
      step("ld100",      0, 1, 16'h0100, 1, 0, 16'h0100, 0, 1, 0);
      step("dec100",     0, 0, 16'h0000, 1, 0, 16'h00FF, 0, 1, 0);
      step("ab100",      0, 0, 16'h0000, 1, 1, 16'h00FF, 0, 0, 1);
      step("ld1000",     0, 1, 16'h1000, 1, 0, 16'h1000, 0, 1, 0);
      step("dec1000",    0, 0, 16'h0000, 1, 0, 16'h0FFF, 0, 1, 0);
      step("ab1000",     0, 0, 16'h0000, 1, 1, 16'h0FFF, 0, 0, 1);

      // enable toggling and ignored load in RUN, then abort at 2
      step("ld5",        0, 1, 16'h0005, 0, 0, 16'h0005, 0, 1, 0);
      step("en1_a",      0, 0, 16'h0000, 1, 0, 16'h0004, 0, 1, 0);
      step("en0_a",      0, 0, 16'h0000, 0, 0, 16'h0004, 0, 1, 0);
      step("en1_b",      0, 0, 16'h0000, 1, 0, 16'h0003, 0, 1, 0);
      step("en0_b",      0, 0, 16'h0000, 0, 0, 16'h0003, 0, 1, 0);
      step("ld_in_run",  0, 1, 16'hAAAA, 0, 0, 16'h0003, 0, 1, 0);
      step("to2",        0, 0, 16'h0000, 1, 0, 16'h0002, 0, 1, 0);
      step("abort_at2",  0, 0, 16'h0000, 1, 1, 16'h0002, 0, 0, 1);
      step("after_ab",   0, 0, 16'h0000, 1, 0, 16'h0002, 0, 0, 1);

      // zero load goes straight to DONE
      step("ld0",        0, 1, 16'h0000, 1, 0, 16'h0000, 1, 1, 0);
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
      step("ld0_park",   0, 0, 16'h0000, 1, 0, 16'h0000, 1, 1, 0);
      step("ld0_park2",  0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1, 0);
      step("ld0_abort",  0, 0, 16'h0000, 1, 1, 16'h0000, 0, 0, 1);
`else
      step("ld0_idle",   0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 1);
`endif

      // load with abort in IDLE is accepted; abort in DONE returns to IDLE
      step("ld_ab_idle", 0, 1, 16'h0002, 1, 1, 16'h0002, 0, 1, 0);
      step("la_1",       0, 0, 16'h0000, 1, 0, 16'h0001, 0, 1, 0);
      step("la_0",       0, 0, 16'h0000, 1, 0, 16'h0000, 1, 1, 0);
      step("ab_done",    0, 0, 16'h0000, 1, 1, 16'h0000, 0, 0, 1);

      // reset mid-run at count 7 from 0x10
      step("ld10",       0, 1, 16'h0010, 1, 0, 16'h0010, 0, 1, 0);
      for (int k = 1; k <= 9; k++) begin
         logic [15:0] want;
         want = 16'h0010 - 16'(k);
         step("run10",   0, 0, 16'h0000, 1, 0, want, 0, 1, 0);
      end
      step("rst_mid",    1, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 1);
      step("rst_idle",   0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 1);

      // reset beats a load
      step("rst_vs_ld",  1, 1, 16'h0005, 1, 1, 16'h0000, 0, 0, 1);

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
      // periodic done with reload 2; enable low at DONE still reloads
      step("ar_ld2",     0, 1, 16'h0002, 1, 0, 16'h0002, 0, 1, 0);
      step("ar_1",       0, 0, 16'h0000, 1, 0, 16'h0001, 0, 1, 0);
      step("ar_0",       0, 0, 16'h0000, 1, 0, 16'h0000, 1, 1, 0);
      step("ar_rl",      0, 1, 16'h7777, 0, 0, 16'h0002, 0, 1, 0);
      step("ar_1b",      0, 0, 16'h0000, 1, 0, 16'h0001, 0, 1, 0);
      step("ar_0b",      0, 0, 16'h0000, 1, 0, 16'h0000, 1, 1, 0);
      step("ar_rl2",     0, 0, 16'h0000, 1, 0, 16'h0002, 0, 1, 0);
      step("ar_abort",   0, 0, 16'h0000, 1, 1, 16'h0002, 0, 0, 1);
`endif

      total++;
      assert (exp_q.size() == 0) else begin
         bad++; $error("FAIL scoreboard_empty got=%0d want=0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got=running want=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/down_counter_bla.md
DOWN_COUNTER_BLA -- requirements
Module: down_counter_bla

Interface
REQ-001 The block SHALL have parameter-free fixed width: 16-bit count built from four 4-bit borrow-lookahead decrement slices.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 load_valid  input  1  load request; accepted when load_valid & load_ready at a rising edge.
REQ-005 load_val  input  16  start value captured on load acceptance.
REQ-006 load_ready  output  1  high only in IDLE.
REQ-007 enable  input  1  decrement qualifier in RUN; 0 holds count.
REQ-008 abort  input  1  cancels an active count.
REQ-009 count  output  16  registered current count.
REQ-010 busy  output  1  high in RUN and DONE.
REQ-011 done  output  1  registered; high exactly while in DONE.
REQ-012 zero  output  1  combinational, count == 16'h0000.

Function
REQ-013 FSM states SHALL be IDLE, RUN, DONE; state, count and the 16-bit reload register are the only storage.
REQ-014 Decrement SHALL be borrow-lookahead per slice: bit0 = ~c0; bit i = ci XOR (all lower slice bits zero); slice borrow-in = all bits of every lower slice zero; no ripple "-1" operator.
REQ-015 IDLE: on accepted load, count <= load_val, reload <= load_val; next state RUN if load_val != 0, DONE if load_val == 0.
REQ-016 IDLE without accepted load: count held, state held.
REQ-017 RUN: on edge with enable=1, count <= count-1; if count was 16'h0001 next state DONE, else RUN.
REQ-018 RUN: on edge with enable=0, count and state held.
REQ-019 load_valid SHALL be ignored outside IDLE; no value captured.
REQ-020 Count SHALL never underflow: decrement from 0 is never performed.
REQ-021 Latency: load of N>0 accepted at edge k, enable held high, gives count=0 and done=1 after edge k+N.
REQ-022 DONE lasts exactly one cycle (count=0, done=1); next edge behaviour per Configuration.
REQ-023 abort=1 in RUN or DONE: next edge state IDLE, count held at current value, done not asserted afterwards; abort has priority over enable.
REQ-024 abort in IDLE SHALL have no effect; a load and abort in the same IDLE cycle accepts the load.

Reset
REQ-025 rst=1 at any edge SHALL force: state IDLE, count 16'h0000, reload 16'h0000, done 0, busy 0, load_ready 1; rst has priority over abort, load and enable.
REQ-026 rst mid-RUN or mid-DONE SHALL discard the count with no done pulse.

Configuration
REQ-027 Macro DOWN_COUNTER_AUTO_RELOAD_EN selects DONE exit behaviour.
REQ-028 Undefined: DONE -> IDLE at next edge; count stays 0; load_ready returns 1.
REQ-029 Defined: DONE -> RUN at next edge with count <= reload (regardless of enable); load_ready stays 0; done pulses once per period of reload+1 cycles with enable high; abort is the only exit besides rst.
REQ-030 Defined with reload == 0: DONE -> DONE, done held high continuously until abort or rst.

Verification
REQ-031 rst, then load 16'h0003 with enable=1 -> count 3,2,1,0; done=1 one cycle on the 0 cycle; then IDLE, load_ready=1.
REQ-032 Load 16'h0100, enable high -> count 16'h00FF after one edge (cross-slice borrow); load 16'h1000 -> 16'h0FFF.
REQ-033 Load 16'h0005, enable toggled 1,0,1,0 -> count 4,4,3,3; load_valid pulsed in RUN with 16'hAAAA -> ignored.
REQ-034 Load 16'h0000 -> DONE next cycle, done=1 one cycle, count 0; abort asserted at count 2 of a run -> IDLE, count 2, no done.
REQ-035 rst asserted at count 7 of a run from 16'h0010 -> next cycle count 0, busy 0, done 0, load_ready 1.
REQ-036 With DOWN_COUNTER_AUTO_RELOAD_EN, load 16'h0002, enable high -> count 2,1,0(done),2,1,0(done) repeating until abort.
